// File: rtl/tensor_core_engine.sv
// tensor_core_engine: DIM x DIM signed matmul/add/ReLU/MAC engine producing LANES result elements per cycle.
// Define TENSOR_CORE_SATURATE_EN to clamp narrowed results and report clamps on sat_flag; otherwise results wrap.
module tensor_core_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM = 3,
  parameter int LANES = 1,
  parameter int ACC_WIDTH = 2*DATA_WIDTH+$clog2(DIM)+1
) (
  input  logic                         tensor_core_clock,
  input  logic                         reset_in,
  input  logic                         tensor_core_register_file_write_enable,
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
  input  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
  input  logic                         should_start_tensor_core,
  input  logic [1:0]                   operation_select,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag,
  output logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM]
);
  localparam int N = DIM*DIM;
  localparam int CW = $clog2(N+LANES);
`ifdef TENSOR_CORE_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - 1;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] a_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] out_q [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] out_d [DIM][DIM];
  logic [1:0] op_q;
  logic sat_q, sat_d, load, last, we;
  logic signed [ACC_WIDTH-1:0] acc, sum;
  int e, r, c;
  assign we = tensor_core_register_file_write_enable;
  assign load = state_q == IDLE && should_start_tensor_core && !we;
  assign last = cnt_q + CW'(LANES) >= CW'(N);
  always_comb begin
    state_d = load ? RUN : (state_q == RUN && !we) ? (last ? DONE : RUN) : IDLE;
    cnt_d = load ? '0 : state_q == RUN ? cnt_q + CW'(LANES) : cnt_q;
  end
  // Each lane owns a distinct element, so MAC reads of out_q never see another lane's write.
  always_comb begin
    out_d = out_q;
    sat_d = load ? 1'b0 : sat_q;
    e = 0;
    r = 0;
    c = 0;
    acc = '0;
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      e = int'(cnt_q) + l;
      r = e / DIM;
      c = e % DIM;
      if (state_q == RUN && e < N) begin
        sum = '0;
        for (int k = 0; k < DIM; k++) sum = sum + ACC_WIDTH'(a_q[r][k]) * ACC_WIDTH'(b_q[k][c]);
        acc = op_q == 2'b00 ? sum :
              op_q == 2'b01 ? ACC_WIDTH'(a_q[r][c]) + ACC_WIDTH'(b_q[r][c]) :
              op_q == 2'b10 ? (a_q[r][c][DATA_WIDTH-1] ? '0 : ACC_WIDTH'(a_q[r][c])) :
              ACC_WIDTH'(out_q[r][c]) + sum;
`ifdef TENSOR_CORE_SATURATE_EN
        out_d[r][c] = acc > MAXV ? DATA_WIDTH'(MAXV) : acc < MINV ? DATA_WIDTH'(MINV) : DATA_WIDTH'(acc);
        if (acc > MAXV || acc < MINV) sat_d = 1'b1;
`else
        out_d[r][c] = DATA_WIDTH'(acc);
`endif
      end
    end
  end
  always_ff @(posedge tensor_core_clock) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sat_q <= 1'b0;
      op_q <= 2'b00;
      out_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      out_q <= out_d;
      if (load) begin
        a_q <= tensor_core_input1;
        b_q <= tensor_core_input2;
        op_q <= operation_select;
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sat_flag = sat_q;
  assign tensor_core_output = out_q;
endmodule

// File: tb/tb_tensor_core_engine.sv
// tb_tensor_core_engine: scoreboard bench for tensor_core_engine with a LANES=1 and a LANES=4 instance.
module tb_tensor_core_engine;
  typedef logic signed [7:0] mat_t [3][3];
  typedef struct {mat_t m; bit sat; int p;} exp_t;
  logic clk = 0, rst = 1, we = 0, start1 = 0, start4 = 0;
  logic [1:0] op_sel = 0;
  logic busy1, done1, sat1, busy4, done4, sat4;
  mat_t in1, in2, out1, out4, exp1, exp4, ident, seq, a100, b50, arelu, zero, m;
  bit s;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int rv[9] = '{-5, 3, 0, -128, 127, 1, -1, 0, 2};

  always #5 clk = ~clk;

  tensor_core_engine u_dut (
    .tensor_core_clock(clk), .reset_in(rst), .tensor_core_register_file_write_enable(we),
    .tensor_core_input1(in1), .tensor_core_input2(in2), .should_start_tensor_core(start1),
    .operation_select(op_sel), .busy(busy1), .done(done1), .sat_flag(sat1), .tensor_core_output(out1));

  tensor_core_engine #(.LANES(4)) u_dut4 (
    .tensor_core_clock(clk), .reset_in(rst), .tensor_core_register_file_write_enable(we),
    .tensor_core_input1(in1), .tensor_core_input2(in2), .should_start_tensor_core(start4),
    .operation_select(op_sel), .busy(busy4), .done(done4), .sat_flag(sat4), .tensor_core_output(out4));

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input mat_t a, input mat_t b, input mat_t old,
                                output mat_t res, output bit sat);
    sat = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int v, mm;
        mm = 0;
        for (int k = 0; k < 3; k++) mm += int'(a[r][k]) * int'(b[k][c]);
        v = op == 0 ? mm : op == 1 ? int'(a[r][c]) + int'(b[r][c]) :
            op == 2 ? (a[r][c] < 0 ? 0 : int'(a[r][c])) : int'(old[r][c]) + mm;
`ifdef TENSOR_CORE_SATURATE_EN
        if (v > 127) begin v = 127; sat = 1; end
        if (v < -128) begin v = -128; sat = 1; end
`endif
        res[r][c] = v[7:0];
      end
  endfunction

  task automatic scramble();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        in1[i][j] = 8'($urandom);
        in2[i][j] = 8'($urandom);
      end
    op_sel = 2'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("%s_out1_e%0d", tag, i*3+j), int'(out1[i][j]), 0);
        chk($sformatf("%s_out4_e%0d", tag, i*3+j), int'(out4[i][j]), 0);
      end
    chk($sformatf("%s_busy", tag), int'(busy1), 0);
    chk($sformatf("%s_done", tag), int'(done1), 0);
    chk($sformatf("%s_sat", tag), int'(sat1), 0);
    chk($sformatf("%s_busy4", tag), int'(busy4), 0);
  endtask

  task automatic no_done(input string tag);
    int hits = 0;
    for (int g = 0; g < 12; g++) begin
      if (done1 || busy1) hits++;
      @(posedge clk); #1;
    end
    chk(tag, hits, 0);
  endtask

  task automatic run(input bit wide, input logic [1:0] op, input mat_t a, input mat_t b, input string tag);
    exp_t x, y;
    mat_t old, res;
    bit st;
    int n = 0;
    if (wide) old = exp4; else old = exp1;
    model(op, a, b, old, res, st);
    x.m = res;
    x.sat = st;
    x.p = wide ? 3 : 9;
    sb.push_back(x);
    if (wide) exp4 = res; else exp1 = res;
    in1 = a;
    in2 = b;
    op_sel = op;
    if (wide) start4 = 1; else start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    start4 = 0;
    scramble();
    for (int g = 0; g < 40; g++) begin
      if (wide ? done4 : done1) break;
      if (wide ? busy4 : busy1) n++;
      @(posedge clk); #1;
    end
    chk($sformatf("%s_done", tag), int'(wide ? done4 : done1), 1);
    chk($sformatf("%s_busy_cycles", tag), n, x.p);
    y = sb.pop_front();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s_e%0d", tag, i*3+j), int'(wide ? out4[i][j] : out1[i][j]), int'(y.m[i][j]));
    chk($sformatf("%s_sat", tag), int'(wide ? sat4 : sat1), int'(y.sat));
    @(posedge clk); #1;
    chk($sformatf("%s_done_once", tag), int'(wide ? done4 : done1), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ident[i][j] = (i == j) ? 8'sd1 : 8'sd0;
        seq[i][j] = 8'(i*3+j+1);
        a100[i][j] = 8'sd100;
        b50[i][j] = 8'sd50;
        arelu[i][j] = 8'(rv[i*3+j]);
        zero[i][j] = '0;
      end
    in1 = zero;
    in2 = zero;
    exp1 = zero;
    exp4 = zero;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_idle("reset");
    run(0, 2'b00, ident, seq, "matmul");
    run(0, 2'b01, a100, b50, "add");
    run(0, 2'b10, arelu, seq, "relu");
    run(0, 2'b00, ident, seq, "matmul2");
    run(0, 2'b11, ident, seq, "mac");
    run(1, 2'b00, ident, seq, "lanes4");
    in1 = ident;
    in2 = seq;
    op_sel = 2'b00;
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy4", int'(busy1), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_idle("rst_mid");
    no_done("rst_no_done");
    exp1 = zero;
    exp4 = zero;
    run(0, 2'b00, ident, seq, "pre_abort");
    model(2'b01, seq, seq, exp1, m, s);
    in1 = seq;
    in2 = seq;
    op_sel = 2'b01;
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    repeat (3) @(posedge clk);
    #1 we = 1;
    @(posedge clk); #1;
    we = 0;
    chk("abort_busy", int'(busy1), 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("abort_e%0d", i*3+j), int'(out1[i][j]), i*3+j < 4 ? int'(m[i][j]) : int'(exp1[i][j]));
    no_done("abort_no_done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tensor_core_engine.md
Name: tensor_core_engine

Overview:
Parametrised successor to the small 3x3 tensor core. Computes DIM x DIM signed matrix multiply, add, ReLU and multiply-accumulate, producing LANES output elements per clock. Adds a start/busy/done handshake, an operand snapshot taken at start, and registered results with overflow saturation. Sits between the operand register file and the result write-back path.

Parameters:
DATA_WIDTH, 8, signed element width of operands and results.
DIM, 3, matrix dimension (DIM x DIM), range 2..8.
LANES, 1, output elements computed per cycle, range 1..DIM*DIM.
ACC_WIDTH, 2*DATA_WIDTH+$clog2(DIM)+1, internal accumulator width; derived, do not override.

Ports:
tensor_core_clock  in  1  sole clock, all state updates on rising edge.
reset_in  in  1  synchronous, active-high reset.
tensor_core_register_file_write_enable  in  1  operand register file is being written; aborts any run.
tensor_core_input1  in  [DIM][DIM] x DATA_WIDTH signed  operand A.
tensor_core_input2  in  [DIM][DIM] x DATA_WIDTH signed  operand B.
should_start_tensor_core  in  1  start request, sampled only in IDLE.
operation_select  in  2  00 matmul, 01 add, 10 ReLU(A), 11 MAC (result += A*B).
busy  out  1  high while RUN.
done  out  1  one-cycle completion pulse.
sat_flag  out  1  sticky: at least one element of the last run clamped.
tensor_core_output  out  [DIM][DIM] x DATA_WIDTH signed  registered result matrix.

Behaviour:
- Reset (reset_in=1 at an edge): state IDLE, counter 0, busy 0, done 0, sat_flag 0, all tensor_core_output elements 0. Reset has priority over every other input, including mid-run.
- FSM states: IDLE, RUN, DONE.
- IDLE: on should_start_tensor_core=1 and write_enable=0, snapshot A, B and operation_select into internal registers, clear counter and sat_flag, go to RUN. Start is ignored in RUN and DONE.
- RUN: every cycle, compute elements e = counter .. counter+LANES-1 (row e/DIM, column e%DIM). Write them into tensor_core_output from snapshot operands, then counter += LANES. Lanes with e >= DIM*DIM are masked and write nothing. After pass P = ceil(DIM*DIM/LANES), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start presented during DONE is not accepted; it must be held into IDLE.
- Latency: start accepted at edge t; busy=1 for cycles t+1..t+P; all results valid and done=1 in the cycle after edge t+P.
- Abort: write_enable=1 in RUN or DONE returns to IDLE. No done pulse. Already-written elements keep their new values; unwritten elements keep their old values.
- Arithmetic: all math in ACC_WIDTH signed, then narrowed to DATA_WIDTH (see optional feature).
  - Matmul: sum over k of A[r][k]*B[k][c].
  - Add: A[r][c]+B[r][c].
  - ReLU: A[r][c] if its sign bit is 0, else 0; never saturates.
  - MAC: sign-extended old output[r][c] plus the matmul sum for that element.
- Snapshot: operand input changes during RUN do not affect the result.

Optional Feature:
TENSOR_CORE_SATURATE_EN.
- Defined: narrowed results clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. sat_flag sets on any clamp during the run and stays set until the next accepted start or reset.
- Undefined: results wrap (low DATA_WIDTH bits kept) and sat_flag is tied to 0.

Test Plan:
1. DIM=3, LANES=1, A=identity, B=[1..9] row-major, op 00 -> output=[1..9]; busy high exactly 9 cycles; done pulses once, in the cycle after the 9th busy cycle.
2. op 01, A all 100, B all 50 -> SATURATE_EN: output all 127, sat_flag=1. Without the macro: output all -106, sat_flag=0.
3. op 10, A=[-5,3,0,-128,127,1,-1,0,2] -> output=[0,3,0,0,127,1,0,0,2]; sat_flag=0.
4. op 00 with A=I, B=[1..9], then op 11 with the same operands -> output=[2,4,...,18].
5. LANES=4, DIM=3, op 00 -> busy 3 cycles; masked lanes 9..11 write nothing; result matches scenario 1. Changing inputs mid-run leaves the result unchanged.
6. reset_in=1 on 4th busy cycle -> next cycle all outputs 0, busy=0, no done. Separately, write_enable on 4th busy cycle -> IDLE, no done; elements 0..3 updated, elements 4..8 hold their prior values.
